// File: rtl/stopwatch_bcd_if.sv
// Control/status bundle between the stopwatch and its neighbours.
// Lap signals exist only when STOPWATCH_LAP_EN is defined.
interface stopwatch_bcd_if;
  logic        i_start_stop;
  logic        i_clear;
  logic        o_tick;
  logic        o_running;
  logic        o_wrap;
  logic [3:0]  o_sec_ones;
  logic [3:0]  o_sec_tens;
  logic [3:0]  o_min_ones;
  logic [3:0]  o_min_tens;
  logic [1:0]  o_dbg_state;
`ifdef STOPWATCH_LAP_EN
  logic        i_lap;
  logic [15:0] o_lap_digits;
  logic        o_lap_valid;

  modport slave (
    input  i_start_stop, i_clear, i_lap,
    output o_tick, o_running, o_wrap, o_sec_ones, o_sec_tens,
           o_min_ones, o_min_tens, o_dbg_state, o_lap_digits, o_lap_valid
  );
  modport master (
    output i_start_stop, i_clear, i_lap,
    input  o_tick, o_running, o_wrap, o_sec_ones, o_sec_tens,
           o_min_ones, o_min_tens, o_dbg_state, o_lap_digits, o_lap_valid
  );
`else
  modport slave (
    input  i_start_stop, i_clear,
    output o_tick, o_running, o_wrap, o_sec_ones, o_sec_tens,
           o_min_ones, o_min_tens, o_dbg_state
  );
  modport master (
    output i_start_stop, i_clear,
    input  o_tick, o_running, o_wrap, o_sec_ones, o_sec_tens,
           o_min_ones, o_min_tens, o_dbg_state
  );
`endif
endinterface

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch driven by a synchronized slow-clock tick.
// Optional lap capture is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd #(
  parameter int p_sync_stages = 2
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_slow_clk,
  stopwatch_bcd_if.slave    io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Controls are single-cycle pulses sampled on i_clk with no backpressure;
  // every status output is valid in every cycle.
  logic [p_sync_stages-1:0] r_sync;
  logic                     r_prev;
  logic                     r_tick;
  state_t                   r_state;
  state_t                   w_state_next;
  logic [3:0]               r_sec_ones;
  logic [3:0]               r_sec_tens;
  logic [3:0]               r_min_ones;
  logic [3:0]               r_min_tens;
  logic                     r_wrap;
  logic                     w_inc;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[p_sync_stages-2:0], i_slow_clk};
      r_prev <= r_sync[p_sync_stages-1];
      r_tick <= r_sync[p_sync_stages-1] & ~r_prev;
    end
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (io_bus.i_clear) begin
      w_state_next = ST_IDLE;
    end else if (io_bus.i_start_stop) begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_RUN;
        ST_RUN:   w_state_next = ST_PAUSE;
        ST_PAUSE: w_state_next = ST_RUN;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // Counting follows the state before the edge, so a start/stop pulse
  // coinciding with a tick in RUN still lets that tick count.
  assign w_inc = r_tick & (r_state == ST_RUN) & ~io_bus.i_clear;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_wrap     <= 1'b0;
    end else if (io_bus.i_clear) begin
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_wrap     <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_inc) begin
        if (r_sec_ones == 4'd9) begin
          r_sec_ones <= 4'd0;
          if (r_sec_tens == 4'd5) begin
            r_sec_tens <= 4'd0;
            if (r_min_ones == 4'd9) begin
              r_min_ones <= 4'd0;
              if (r_min_tens == 4'd5) begin
                r_min_tens <= 4'd0;
                r_wrap     <= 1'b1;
              end else begin
                r_min_tens <= r_min_tens + 4'd1;
              end
            end else begin
              r_min_ones <= r_min_ones + 4'd1;
            end
          end else begin
            r_sec_tens <= r_sec_tens + 4'd1;
          end
        end else begin
          r_sec_ones <= r_sec_ones + 4'd1;
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [15:0] r_lap_digits;
  logic        r_lap_valid;

  // Capture uses the registered count, i.e. the value before any same-edge increment.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_lap_digits <= 16'd0;
      r_lap_valid  <= 1'b0;
    end else if (io_bus.i_clear) begin
      r_lap_digits <= 16'd0;
      r_lap_valid  <= 1'b0;
    end else if (io_bus.i_lap && (r_state != ST_IDLE)) begin
      r_lap_digits <= {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
      r_lap_valid  <= 1'b1;
    end
  end

  assign io_bus.o_lap_digits = r_lap_digits;
  assign io_bus.o_lap_valid  = r_lap_valid;
`endif

  assign io_bus.o_tick      = r_tick;
  assign io_bus.o_running   = (r_state == ST_RUN);
  assign io_bus.o_wrap      = r_wrap;
  assign io_bus.o_sec_ones  = r_sec_ones;
  assign io_bus.o_sec_tens  = r_sec_tens;
  assign io_bus.o_min_ones  = r_min_ones;
  assign io_bus.o_min_tens  = r_min_tens;
  assign io_bus.o_dbg_state = r_state;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd: tick latency, carries, wrap,
// pause/clear, reset and (with STOPWATCH_LAP_EN) lap capture.
module tb_stopwatch_bcd;
  localparam int S = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slow = 1'b0;

  always #10 clk = ~clk;

  stopwatch_bcd_if sw();

  stopwatch_bcd #(.p_sync_stages(S)) dut (
    .i_clk      (clk),
    .reset      (rst),
    .i_slow_clk (slow),
    .io_bus     (sw)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_ticks  = 0;
  int          t0;
  int          m_secs   = 0;
  bit          m_run    = 1'b0;
  bit          pend     = 1'b0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;
  logic [15:0] dig;

  assign dig = {sw.o_min_tens, sw.o_min_ones, sw.o_sec_tens, sw.o_sec_ones};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int mm;
    int ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Scoreboard: one expected {running, wrap, digits} per driven slow-clock rise,
  // compared in the cycle after the tick appears.
  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: tick seen with no expectation at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_digits",  dig,          mon_e[15:0]);
        check_eq("sb_wrap",    sw.o_wrap,    mon_e[16]);
        check_eq("sb_running", sw.o_running, mon_e[17]);
      end
    end
    pend = sw.o_tick && !rst;
    if (sw.o_tick) n_ticks++;
  end

  // One slow-clock period; optional clear/start_stop lands in the tick cycle.
  task automatic slow_tick(input bit do_clear, input bit do_ss);
    logic wr;
    wr = 1'b0;
    if (do_clear) begin
      m_secs = 0;
      m_run  = 1'b0;
    end else begin
      if (m_run) begin
        m_secs = (m_secs + 1) % 3600;
        wr = (m_secs == 0);
      end
      if (do_ss) m_run = !m_run;
    end
    exp_q.push_back({m_run, wr, to_bcd(m_secs)});
    slow = 1'b1;
    @(negedge clk);
    check_eq("tick_n0", sw.o_tick, 1'b0);
    repeat (S - 1) begin
      @(negedge clk);
      check_eq("tick_early", sw.o_tick, 1'b0);
    end
    @(negedge clk);
    check_eq("tick_hi", sw.o_tick, 1'b1);
    sw.i_clear      = do_clear;
    sw.i_start_stop = do_ss;
    @(negedge clk);
    check_eq("tick_lo", sw.o_tick, 1'b0);
    sw.i_clear      = 1'b0;
    sw.i_start_stop = 1'b0;
    slow            = 1'b0;
    @(negedge clk);
    check_eq("wrap_pulse", sw.o_wrap, 1'b0);
    repeat (S + 1) @(negedge clk);
  endtask

  task automatic pulse_ss();
    sw.i_start_stop = 1'b1;
    @(negedge clk);
    sw.i_start_stop = 1'b0;
    m_run = !m_run;
    check_eq("ss_running", sw.o_running, m_run);
  endtask

  task automatic pulse_clear();
    sw.i_clear = 1'b1;
    @(negedge clk);
    sw.i_clear = 1'b0;
    m_run  = 1'b0;
    m_secs = 0;
    check_eq("clr_digits", dig, 16'h0000);
    check_eq("clr_state", sw.o_dbg_state, ST_IDLE);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    sw.i_start_stop = 1'b0;
    sw.i_clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
    sw.i_lap        = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_digits",  dig,            16'h0000);
    check_eq("rst_tick",    sw.o_tick,      1'b0);
    check_eq("rst_wrap",    sw.o_wrap,      1'b0);
    check_eq("rst_running", sw.o_running,   1'b0);
    check_eq("rst_state",   sw.o_dbg_state, ST_IDLE);
`ifdef STOPWATCH_LAP_EN
    check_eq("rst_lap",     sw.o_lap_digits, 16'h0000);
    check_eq("rst_lap_v",   sw.o_lap_valid,  1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // start, first tick exercises latency
    pulse_ss();
    check_eq("run_state", sw.o_dbg_state, ST_RUN);
    slow_tick(1'b0, 1'b0);
    check_eq("first_sec", dig, 16'h0001);

    // carries up to 12:34
    repeat (598) slow_tick(1'b0, 1'b0);
    check_eq("at_0959", dig, 16'h0959);
    slow_tick(1'b0, 1'b0);
    check_eq("at_1000", dig, 16'h1000);
    repeat (154) slow_tick(1'b0, 1'b0);
    check_eq("at_1234", dig, 16'h1234);

    // asynchronous reset mid-count
    #2 rst = 1'b1;
    #1;
    check_eq("arst_digits",  dig,            16'h0000);
    check_eq("arst_running", sw.o_running,   1'b0);
    check_eq("arst_state",   sw.o_dbg_state, ST_IDLE);
    check_eq("arst_tick",    sw.o_tick,      1'b0);
    m_secs = 0;
    m_run  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    t0 = n_ticks;
    repeat (3) slow_tick(1'b0, 1'b0);
    check_eq("idle_ticks",  n_ticks - t0, 3);
    check_eq("idle_digits", dig, 16'h0000);

    // pause and clear
    pulse_ss();
    repeat (5) slow_tick(1'b0, 1'b0);
    pulse_ss();
    check_eq("pause_state", sw.o_dbg_state, ST_PAUSE);
    repeat (4) slow_tick(1'b0, 1'b0);
    check_eq("pause_hold", dig, 16'h0005);
    pulse_ss();
    slow_tick(1'b0, 1'b0);
    check_eq("resume", dig, 16'h0006);
    slow_tick(1'b1, 1'b0);
    check_eq("clr_tick_digits", dig, 16'h0000);
    check_eq("clr_tick_state", sw.o_dbg_state, ST_IDLE);

    // start/stop on the same cycle as a RUN tick
    pulse_ss();
    repeat (7) slow_tick(1'b0, 1'b0);
    slow_tick(1'b0, 1'b1);
    check_eq("ss_tick_digits", dig, 16'h0008);
    check_eq("ss_tick_state", sw.o_dbg_state, ST_PAUSE);

`ifdef STOPWATCH_LAP_EN
    pulse_clear();
    sw.i_lap = 1'b1;
    @(negedge clk);
    sw.i_lap = 1'b0;
    check_eq("lap_idle_v", sw.o_lap_valid, 1'b0);
    pulse_ss();
    repeat (83) slow_tick(1'b0, 1'b0);
    sw.i_lap = 1'b1;
    @(negedge clk);
    sw.i_lap = 1'b0;
    check_eq("lap_digits", sw.o_lap_digits, 16'h0123);
    check_eq("lap_valid",  sw.o_lap_valid,  1'b1);
    slow_tick(1'b0, 1'b0);
    check_eq("lap_cont",   dig,             16'h0124);
    check_eq("lap_hold",   sw.o_lap_digits, 16'h0123);
    pulse_clear();
    check_eq("lap_clr",    sw.o_lap_digits, 16'h0000);
    check_eq("lap_clr_v",  sw.o_lap_valid,  1'b0);
`endif

    // full range and wrap
    pulse_clear();
    pulse_ss();
    repeat (3599) slow_tick(1'b0, 1'b0);
    check_eq("at_5959", dig, 16'h5959);
    slow_tick(1'b0, 1'b0);
    check_eq("wrap_digits",  dig,          16'h0000);
    check_eq("wrap_running", sw.o_running, 1'b1);

    repeat (4) @(negedge clk);
    check_eq("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
